rf_alu_sequencer: RTL

RF_ALU_SEQUENCER -- requirements
Module: rf_alu_sequencer

---
 rtl/rf_alu_sequencer.sv | 121 ++++++++++++
 1 files changed

// File: rtl/rf_alu_sequencer.sv
// Multi-cycle sequencer: reads two registers, drives an external ALU, writes the
// result back and returns a response, one command at a time.
module rf_alu_sequencer #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic [3:0]        cmd_op,
  input  logic [ADDR_W-1:0] cmd_ra,
  input  logic [ADDR_W-1:0] cmd_rb,
  input  logic [ADDR_W-1:0] cmd_wa,
  output logic [ADDR_W-1:0] raA,
  output logic [ADDR_W-1:0] raB,
  input  logic [DATA_W-1:0] rdA,
  input  logic [DATA_W-1:0] rdB,
  output logic [ADDR_W-1:0] wa,
  output logic              wen,
  output logic [DATA_W-1:0] wd,
  output logic [DATA_W-1:0] alu_a,
  output logic [DATA_W-1:0] alu_b,
  output logic [3:0]        alu_op,
  input  logic [DATA_W-1:0] alu_out,
  input  logic              alu_zero,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [DATA_W-1:0] rsp_result,
  output logic              rsp_zero,
  output logic              rsp_err,
  output logic [15:0]       op_count
);

  typedef enum logic [2:0] {IDLE, READ, EXEC, WRITE, RESP} state_t;

  state_t state, state_nxt;

  logic [3:0]        op_p0;
  logic [ADDR_W-1:0] ra_p0, rb_p0, wa_p0;
  logic              err_p0;
  logic              accept, rsp_done;

  function automatic logic op_ok(input logic [3:0] op);
    case (op)
      4'b0000, 4'b0001, 4'b0010, 4'b0110, 4'b0111, 4'b1100: op_ok = 1'b1;
      default:                                              op_ok = 1'b0;
    endcase
  endfunction

  assign accept   = (state == IDLE) && cmd_valid && cmd_ready;
  assign rsp_done = (state == RESP) && rsp_ready;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (accept) state_nxt = READ;
      READ:    state_nxt = EXEC;
      EXEC:    state_nxt = WRITE;
      WRITE:   state_nxt = RESP;
      RESP:    if (rsp_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // cmd_ready is registered so it stays low until the first edge after reset releases
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      cmd_ready  <= 1'b0;
      op_p0      <= '0;
      ra_p0      <= '0;
      rb_p0      <= '0;
      wa_p0      <= '0;
      err_p0     <= 1'b0;
      alu_a      <= '0;
      alu_b      <= '0;
      alu_op     <= '0;
      rsp_result <= '0;
      rsp_zero   <= 1'b0;
      rsp_err    <= 1'b0;
      op_count   <= '0;
    end else begin
      cmd_ready <= (state_nxt == IDLE);
      // accept: latch the command
      if (accept) begin
        op_p0  <= cmd_op;
        ra_p0  <= cmd_ra;
        rb_p0  <= cmd_rb;
        wa_p0  <= cmd_wa;
        err_p0 <= !op_ok(cmd_op);
      end
      // READ: register operands for the ALU
      if (state == READ) begin
        alu_a  <= rdA;
        alu_b  <= rdB;
        alu_op <= op_p0;
      end
      // EXEC: capture the ALU result, zeroed for illegal ops
      if (state == EXEC) begin
        rsp_result <= err_p0 ? '0 : alu_out;
        rsp_zero   <= err_p0 ? 1'b0 : alu_zero;
        rsp_err    <= err_p0;
      end
      if (rsp_done) op_count <= op_count + 16'd1;
    end
  end

  assign raA       = (state == READ) ? ra_p0 : '0;
  assign raB       = (state == READ) ? rb_p0 : '0;
  assign wa        = wa_p0;
  assign wd        = rsp_result;
  // R0 is hardwired to zero, so writes to it are dropped
  assign wen       = (state == WRITE) && (wa_p0 != '0) && !err_p0;
  assign rsp_valid = (state == RESP);

endmodule
